// File: rtl/crc_frame_arbiter.sv
// Round-robin share of one bit-serial CRC-16 engine between two payload sources; emits {payload, crc} with a source tag.
// Latency: frame valid 177 cycles after accept; sources are held off (ready low) while a frame is shifting or awaiting out_ready.
module crc_frame_arbiter #(
  parameter int          PAYLOAD_W = 176,
  parameter logic [15:0] POLY      = 16'h1021,
  parameter logic [15:0] INIT      = 16'h0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  input  logic [PAYLOAD_W-1:0]   req0_data,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [PAYLOAD_W-1:0]   req1_data,
  output logic                   req1_ready,
  output logic                   out_valid,
  output logic [PAYLOAD_W+15:0]  out_data,
  output logic                   out_src,
  input  logic                   out_ready,
  output logic                   busy
);

  localparam int CNT_W = $clog2(PAYLOAD_W);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state, state_nxt;
  logic [PAYLOAD_W-1:0] payload_q;
  logic [15:0]          crc_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 src_q;
  logic                 last_grant;
  logic                 grant0, grant1;
  logic                 fb;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // On contention the source that did not win last time is granted.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    grant0     = req0_valid && (!req1_valid || last_grant);
    grant1     = req1_valid && (!req0_valid || !last_grant);
    case (state)
      IDLE: begin
        req0_ready = grant0 && !rst;
        req1_ready = grant1 && !rst;
        if (grant0 || grant1) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt_q == '0) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign fb = crc_q[15] ^ payload_q[cnt_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      crc_q      <= '0;
      cnt_q      <= '0;
      src_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            payload_q  <= grant0 ? req0_data : req1_data;
            src_q      <= grant1;
            last_grant <= grant1;
            crc_q      <= INIT;
            cnt_q      <= CNT_W'(PAYLOAD_W - 1);
          end
        end
        SHIFT: begin
          crc_q <= {crc_q[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
          // Counter parks at zero so the bit index stays in range while in DONE.
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_data = (state == DONE) ? {payload_q, crc_q} : '0;
  assign out_src  = (state == DONE) && src_q;

endmodule

// File: tb/tb_crc_frame_arbiter.sv
// Randomized and directed bench for crc_frame_arbiter against a transaction-level reference model.
module tb_crc_frame_arbiter;

  localparam int PW = 176;

  logic          clk;
  logic          rst;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [PW-1:0] req0_data, req1_data;
  logic          out_valid, out_src, out_ready, busy;
  logic [PW+15:0] out_data;

  crc_frame_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // CRC-16/XMODEM by polynomial long division, MSB first.
  function automatic logic [15:0] crc16(input logic [PW-1:0] p);
    logic [15:0] c;
    c = 16'h0000;
    for (int i = PW - 1; i >= 0; i--)
      c = (c[15] ^ p[i]) ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction

  function automatic logic [PW-1:0] rnd_pl();
    logic [191:0] t;
    t = '0;
    for (int i = 0; i < 6; i++) t = {t[159:0], 32'($urandom())};
    return t[PW-1:0];
  endfunction

  // Reference model: a frame is either absent or has aged m_k edges since its accept edge.
  bit             m_act  = 1'b0;
  bit             m_last = 1'b1;
  int             m_k    = 0;
  bit             m_src  = 1'b0;
  logic [191:0]   m_frame = '0;
  bit             m_acc0 = 1'b0, m_acc1 = 1'b0;
  int             m_acc_n = 0, m_hs_n = 0, m_abort_n = 0;
  int             cyc = 0, acc_cyc = 0, rise_cyc = 0;
  bit             prev_ov = 1'b0;
  bit             ev, g0, g1;
  logic [191:0]   dq[$];
  bit             sq[$];

  always @(negedge clk) begin
    cyc++;
    ev = m_act && (m_k >= PW);
    g0 = !m_act && req0_valid && (!req1_valid || m_last);
    g1 = !m_act && req1_valid && (!req0_valid || !m_last);
    chk("req0_ready", req0_ready, g0 && !rst);
    chk("req1_ready", req1_ready, g1 && !rst);
    chk("ready_excl", req0_ready && req1_ready, 1'b0);
    chk("out_valid", out_valid, ev);
    chk("busy", busy, m_act);
    if (ev) begin
      chk("out_data", out_data, m_frame);
      chk("out_src", out_src, m_src);
    end
    if (out_valid && !prev_ov) rise_cyc = cyc;
    prev_ov = out_valid;
    if (ev && out_valid && out_ready) begin
      dq.push_back(out_data);
      sq.push_back(out_src);
    end
    m_acc0 = 1'b0;
    m_acc1 = 1'b0;
    if (rst) begin
      if (m_act) m_abort_n++;
      m_act  = 1'b0;
      m_last = 1'b1;
    end else if (!m_act) begin
      if (g0 || g1) begin
        m_act   = 1'b1;
        m_k     = 0;
        m_src   = g1;
        m_last  = g1;
        m_frame = g1 ? {req1_data, crc16(req1_data)} : {req0_data, crc16(req0_data)};
        m_acc0  = g0;
        m_acc1  = g1;
        m_acc_n++;
        acc_cyc = cyc;
      end
    end else if (ev) begin
      if (out_ready) begin
        m_act = 1'b0;
        m_hs_n++;
      end
    end else begin
      m_k++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit src, input logic [PW-1:0] d);
    bit got;
    got = 1'b0;
    if (src) begin req1_valid = 1'b1; req1_data = d; end
    else     begin req0_valid = 1'b1; req0_data = d; end
    for (int n = 0; n < 3000 && !got; n++) begin
      tick();
      got = src ? m_acc1 : m_acc0;
    end
    if (!got) timeout(src ? "send1" : "send0");
    if (src) req1_valid = 1'b0;
    else     req0_valid = 1'b0;
  endtask

  task automatic wait_hs(input int target);
    int n;
    n = 0;
    while (m_hs_n < target && n < 3000) begin
      tick();
      n++;
    end
    if (m_hs_n < target) timeout("wait_hs");
  endtask

  int           drv_done;
  logic [191:0] fr, hd;
  bit           hsrc;
  logic [PW-1:0] pl;

  initial begin
    rst = 1'b1; out_ready = 1'b1;
    req0_valid = 1'b1; req0_data = '0;
    req1_valid = 1'b0; req1_data = '0;
    chk("crc_model_zero", crc16('0), 16'h0000);
    chk("crc_model_one", crc16(176'h1), 16'h1021);
    chk("crc_model_check", crc16({104'h0, 72'h313233343536373839}), 16'h31C3);
    repeat (3) tick();
    chk("rst_req0_ready", req0_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 192'h0);
    chk("rst_out_src", out_src, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;

    // zero payload from source 0, with latency check
    dq.delete(); sq.delete();
    send(1'b0, '0);
    wait_hs(1);
    chk("t1_count", dq.size(), 1);
    if (dq.size() > 0) begin
      chk("t1_data", dq[0], 192'h0);
      chk("t1_src", sq[0], 1'b0);
    end
    chk("t1_latency", rise_cyc - acc_cyc, 177);

    dq.delete(); sq.delete();
    send(1'b1, 176'h1);
    wait_hs(m_hs_n + 1);
    if (dq.size() > 0) begin
      fr = dq[0];
      chk("t2_crc", fr[15:0], 16'h1021);
      chk("t2_src", sq[0], 1'b1);
    end else timeout("t2_frame");

    dq.delete(); sq.delete();
    send(1'b0, {104'h0, 72'h313233343536373839});
    wait_hs(m_hs_n + 1);
    if (dq.size() > 0) begin
      fr = dq[0];
      chk("t3_crc", fr[15:0], 16'h31C3);
    end else timeout("t3_frame");

    // contention straight after reset alternates starting with source 0
    rst = 1'b1; tick(); rst = 1'b0;
    dq.delete(); sq.delete();
    fork
      for (int i = 0; i < 3; i++) send(1'b0, rnd_pl());
      for (int i = 0; i < 3; i++) send(1'b1, rnd_pl());
    join
    wait_hs(m_hs_n + 1);
    chk("alt_count", sq.size(), 6);
    for (int i = 0; i < 6 && i < sq.size(); i++) chk("alt_src", sq[i], i % 2);

    // output stall in DONE with a competing request pending
    out_ready = 1'b0;
    send(1'b0, rnd_pl());
    pl = rnd_pl();
    req1_valid = 1'b1; req1_data = pl;
    for (int n = 0; n < 400 && !out_valid; n++) tick();
    if (!out_valid) timeout("hold_valid");
    hd = out_data; hsrc = out_src;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_data", out_data, hd);
      chk("hold_src", out_src, hsrc);
      chk("hold_ready", {req0_ready, req1_ready}, 2'b00);
    end
    out_ready = 1'b1;
    tick();
    chk("hold_drop", out_valid, 1'b0);
    send(1'b1, pl);
    wait_hs(m_hs_n + 1);

    // reset mid-shift discards the frame
    send(1'b1, rnd_pl());
    repeat (90) tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_ready", {req0_ready, req1_ready}, 2'b00);
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_data", out_data, 192'h0);
    chk("mid_rst_src", out_src, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    rst = 1'b0;
    dq.delete(); sq.delete();
    send(1'b1, 176'h1);
    wait_hs(m_hs_n + 1);
    if (dq.size() > 0) begin
      fr = dq[0];
      chk("mid_rst_crc", fr[15:0], 16'h1021);
    end else timeout("mid_rst_frame");

    // random traffic with random backpressure
    drv_done = 0;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          repeat ($urandom_range(0, 300)) tick();
          send(1'b0, rnd_pl());
        end
        drv_done++;
      end
      begin
        for (int i = 0; i < 12; i++) begin
          repeat ($urandom_range(0, 300)) tick();
          send(1'b1, rnd_pl());
        end
        drv_done++;
      end
      begin
        while (drv_done < 2) begin
          out_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
      end
    join
    out_ready = 1'b1;
    wait_hs(m_acc_n - m_abort_n);
    chk("drain", m_hs_n + m_abort_n, m_acc_n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/crc_frame_arbiter.md
# crc_frame_arbiter

Shares one bit-serial CRC-16 engine between two payload sources. Each source offers a 176-bit payload over a valid/ready handshake. A round-robin arbiter grants one source at a time, the engine shifts the payload MSB-first, and the block emits the 192-bit frame {payload, crc} with a source tag. It sits between the payload producers and the frame transmit path, replacing per-source parallel CRC logic.

## Interface
- PAYLOAD_W, 176, payload width in bits; frame width is PAYLOAD_W+16
- POLY, 16'h1021, CRC-16 generator polynomial (x^16+x^12+x^5+1, top bit implicit)
- INIT, 16'h0000, CRC register value loaded at payload accept
- clk  input  1  single clock, all logic on posedge
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  source 0 payload available
- req0_data  input  PAYLOAD_W  source 0 payload
- req0_ready  output  1  source 0 payload accepted this cycle when high with req0_valid
- req1_valid  input  1  source 1 payload available
- req1_data  input  PAYLOAD_W  source 1 payload
- req1_ready  output  1  source 1 payload accepted this cycle when high with req1_valid
- out_valid  output  1  frame available on out_data
- out_data  output  PAYLOAD_W+16  {payload, crc[15:0]}
- out_src  output  1  source index of the frame on out_data
- out_ready  input  1  downstream consumes frame when high with out_valid
- busy  output  1  high in SHIFT or DONE

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE grant rule:
  - Only req0 valid: grant 0. Only req1 valid: grant 1.
  - Both valid: grant the source not in last_grant.
  - Neither valid: no grant; both ready signals stay low.
- In IDLE, reqN_ready = granted source N. Ready is combinational from state, valids and last_grant. There is no path from out_ready.
- On accept:
  - Latch the payload into a shift register and the source into a src register.
  - Set last_grant to the accepted source.
  - Load crc = INIT and bit counter = PAYLOAD_W-1.
  - Go to SHIFT.
- SHIFT, each cycle:
  - d = payload[counter]; fb = crc[15]^d; crc <= {crc[14:0],1'b0} ^ (fb ? POLY : 0).
  - Decrement counter. When counter==0 on this cycle, go to DONE.
- No reflection and no final XOR (CRC-16/XMODEM).
- DONE:
  - out_valid=1; out_data={latched payload, crc}; out_src=src. All three are held stable while out_ready is low.
  - On out_valid&&out_ready, go to IDLE. out_valid drops the next cycle.
- Both ready signals are low in SHIFT and DONE. New requests wait with valid held; a source must not drop valid or change data before its ready.
- Requests arriving during SHIFT/DONE are arbitrated on return to IDLE, using the updated last_grant.
- Reset (any state, including mid-SHIFT or DONE with out_valid high):
  - Go to IDLE and discard any in-progress frame.
  - last_grant=1, so source 0 wins the first contention.
  - crc=0, counter=0.

## Timing
- Reset values:
  - req0_ready=0, req1_ready=0 (forced low while rst high).
  - out_valid=0, out_data=0, out_src=0, busy=0.
- Accept occurs at edge E0. SHIFT occupies the next PAYLOAD_W cycles (176). out_valid is high in the cycle after edge E176, i.e. 177 cycles after accept.
- If out_ready is high in the first DONE cycle, IDLE follows. The earliest next accept is 2 cycles after out_valid first rises. The minimum frame interval is 178 cycles.
- busy rises the cycle after accept and falls the cycle after the output handshake.
- Simultaneous valid on both sources while idle: exactly one ready is high. The other source is served next frame if it is still valid.
- out_ready high while out_valid low: ignored.

## Test plan
- req0_data=0, out_ready=1 -> out_data=192'h0, out_src=0, out_valid rises 177 cycles after the accept edge.
- req1_data=176'h1 (only source valid) -> crc=16'h1021, out_src=1.
- req0_data={104'h0, 72'h313233343536373839} -> crc=16'h31C3 (XMODEM check value).
- Both valid continuously with distinct payloads, out_ready=1 -> frames alternate out_src 0,1,0,1. The first grant after reset is source 0, and ready never asserts for both sources in the same cycle.
- Hold out_ready=0 for 50 cycles in DONE -> out_valid, out_data and out_src stay constant, both readies stay 0. Set out_ready=1 -> one handshake, out_valid=0 next cycle.
- Assert rst for 1 cycle at SHIFT cycle 90 -> next cycle all outputs are at reset values. A subsequent 176'h1 request on req1 yields a correct crc of 16'h1021.
